// File: rtl/sram_nbt_resp_pkg.sv
// sram_nbt_resp_pkg: GCL SRAM pin-protocol types shared by the NBT SRAM responder.
// Rev 1.0
`default_nettype none
package sram_nbt_resp_pkg;

    localparam int A_size    = 18;
    localparam int DQ_size   = 9;
    localparam int DQ_W      = 4 * DQ_size;
    localparam int SR_RD_LAT = 2;

    typedef enum logic [1:0] {SR_NOP, SR_RD, SR_WR} srop_t;

    typedef struct packed {
        srop_t             op;
        logic [A_size-1:0] adr;
        logic [3:0]        bw_n;
    } srcyc_t;

    localparam srcyc_t SRCYC_NOP = '{op: SR_NOP, adr: '0, bw_n: 4'hF};

    // Lane i of the word is DQ[i*DQ_size +: DQ_size] and is enabled by bw_n[i].
    function automatic logic [DQ_W-1:0] bw_merge(input logic [DQ_W-1:0] old_w,
                                                 input logic [DQ_W-1:0] new_w,
                                                 input logic [3:0]      bw_n);
        logic [DQ_W-1:0] m;
        m = old_w;
        for (int i = 0; i < 4; i++) begin
            if (!bw_n[i]) m[i*DQ_size +: DQ_size] = new_w[i*DQ_size +: DQ_size];
        end
        return m;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sram_nbt_array.sv
// sram_nbt_array: DEPTH x 36 byte-enabled 1R1W array, registered read with same-edge write bypass.
// Rev 1.0
`default_nettype none
module sram_nbt_array
    import sram_nbt_resp_pkg::*;
#(
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  rd_en,
    input  logic [DEPTH_LOG2-1:0] rd_adr,
    output logic [DQ_W-1:0]       rd_data,
    input  logic                  wr_en,
    input  logic [DEPTH_LOG2-1:0] wr_adr,
    input  logic [3:0]            wr_bw_n,
    input  logic [DQ_W-1:0]       wr_data
);

    logic [DQ_W-1:0] mem [2**DEPTH_LOG2];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < 4; i++) begin
                if (!wr_bw_n[i]) mem[wr_adr][i*DQ_size +: DQ_size] <= wr_data[i*DQ_size +: DQ_size];
            end
        end
    end

    // A read colliding with a commit returns the merged word, not the stale one.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rd_data <= '0;
        end else if (rd_en) begin
            if (wr_en && (wr_adr == rd_adr)) rd_data <= bw_merge(mem[rd_adr], wr_data, wr_bw_n);
            else                              rd_data <= mem[rd_adr];
        end
    end

endmodule
`default_nettype wire

// File: rtl/sram_nbt_resp.sv
// sram_nbt_resp: pipelined NBT SRAM bank responder (RD/WR/CP/NOP) on the shared GCL DQ bus.
// Rev 1.0
`default_nettype none
module sram_nbt_resp
    import sram_nbt_resp_pkg::*;
#(
    parameter int DEPTH_LOG2 = 10,
    parameter int BANK_ID    = 0,
    parameter int TCO        = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [A_size-1:0] A,
    input  logic              WE_n,
    input  logic              ADV,
    input  logic [3:0]        BW_n,
    input  logic              CE_n,
    input  logic              CE2,
    input  logic              CE2_n,
    input  logic              CKE_n,
    input  logic              ZZ,
    input  logic              MODE,
    input  logic              OE_n,
    inout  wire  [DQ_W-1:0]   DQ,
    output logic              err
);

    logic              sel;
    logic              active;
    logic              adv_err;
    logic              rd_en;
    logic              wr_en;
    logic              drive;
    logic              err_set;
    logic [DQ_W-1:0]   dout_r;
    srcyc_t            cyc;
    srcyc_t            s1;
    srcyc_t            s2;
    logic              have_load;
    srop_t             load_op;
    logic [A_size-1:0] load_adr;
    logic [1:0]        cnt;

    assign sel    = !CE_n && CE2 && !CE2_n;
    assign active = sel && !ZZ;

    always_comb begin
        cyc     = SRCYC_NOP;
        adv_err = 1'b0;
        if (active) begin
            if (!ADV) begin
                cyc = '{op: (WE_n ? SR_RD : SR_WR), adr: A, bw_n: BW_n};
            end else if (have_load) begin
                cyc = '{op: load_op,
                        adr: {load_adr[A_size-1:2], load_adr[1:0] + cnt + 2'd1},
                        bw_n: BW_n};
            end else begin
                adv_err = 1'b1;
            end
        end
    end

    assign rd_en = reset_n && !CKE_n && (s1.op == SR_RD);
    assign wr_en = reset_n && !CKE_n && (s2.op == SR_WR);

    assign err_set = (wr_en && !OE_n)
                   || adv_err
                   || (sel && MODE)
                   || (wr_en && !(&s2.bw_n) && $isunknown(DQ));

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            s1        <= SRCYC_NOP;
            s2        <= SRCYC_NOP;
            have_load <= 1'b0;
            load_op   <= SR_NOP;
            load_adr  <= '0;
            cnt       <= 2'd0;
            err       <= 1'b0;
        end else if (!CKE_n) begin
            s1 <= cyc;
            s2 <= s1;
            if (active && !ADV) begin
                have_load <= 1'b1;
                load_op   <= WE_n ? SR_RD : SR_WR;
                load_adr  <= A;
                cnt       <= 2'd0;
            end else if (active && have_load) begin
                cnt <= cnt + 2'd1;
            end
            if (err_set) err <= 1'b1;
        end
    end

    sram_nbt_array #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_array (
        .clk     (clk),
        .reset_n (reset_n),
        .rd_en   (rd_en),
        .rd_adr  (s1.adr[DEPTH_LOG2-1:0]),
        .rd_data (dout_r),
        .wr_en   (wr_en),
        .wr_adr  (s2.adr[DEPTH_LOG2-1:0]),
        .wr_bw_n (s2.bw_n),
        .wr_data (DQ)
    );

    // Output enable and reset act on the pad combinationally so the bus is freed at once.
    assign drive = (s2.op == SR_RD) && !OE_n && reset_n && !ZZ;
    assign DQ    = drive ? dout_r : {DQ_W{1'bz}};

    // BANK_ID and TCO only tag messages / model pad delay; upper address bits alias.
    logic unused_bits;
    assign unused_bits = ^{s2.adr, BANK_ID[0], TCO[0]};

endmodule
`default_nettype wire
